// File: rtl/button_event_if.sv
// Event bus between the button event generator and the UI logic that uses it.
// The master drives the debounced button level. The slave returns the one-cycle events and the status outputs.
interface button_event_if;
   logic       boton;
   logic       press_p;
   logic       release_p;
   logic       long_p;
   logic       repeat_p;
   logic       held;
   logic [7:0] evt_cnt;

   modport master (
      output boton,
      input  press_p, release_p, long_p, repeat_p, held, evt_cnt
   );

   modport slave (
      input  boton,
      output press_p, release_p, long_p, repeat_p, held, evt_cnt
   );
endinterface

// File: rtl/button_event_gen.sv
// Turns a debounced button level into one-cycle press/release/long/repeat events and counts presses.
// Optional feature macro BUTTON_REPEAT_EN: when it is defined, a long hold also produces auto-repeat pulses.
module button_event_gen #(
   parameter int CNT_W        = 24,
   parameter int LONG_TICKS   = 12500000,
   parameter int REPEAT_TICKS = 2500000
) (
   input  logic          clk,
   input  logic          rst_n,
   button_event_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PRESS = 2'd1,
      ST_LONG  = 2'd2
   } state_t;

   localparam int MAX_TICKS = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);

   // Illegal parameter sets stop elaboration instead of building a counter that can overflow
   if ((LONG_TICKS < 2) || (REPEAT_TICKS < 2) || ((64'd1 << CNT_W) <= 64'(MAX_TICKS))) begin : g_bad_params
      $error("button_event_gen: illegal tick parameters for CNT_W");
   end

   state_t           state_r, state_s;
   logic [CNT_W-1:0] cnt_r, cnt_s;
   logic             prev_r;
   logic             rise_s;
   logic             press_r, press_s;
   logic             release_r, release_s;
   logic             long_r, long_s;
   logic             held_r, held_s;
   logic [7:0]       evt_r, evt_s;
`ifdef BUTTON_REPEAT_EN
   localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_TICKS - 1);
   logic             repeat_r, repeat_s;
`endif

   assign rise_s = bus.boton & ~prev_r;

   // Next-state and next-output logic; release always wins over a terminal count
   always_comb begin
      state_s   = state_r;
      cnt_s     = cnt_r;
      press_s   = 1'b0;
      release_s = 1'b0;
      long_s    = 1'b0;
      evt_s     = evt_r;
`ifdef BUTTON_REPEAT_EN
      repeat_s  = 1'b0;
`endif
      case (state_r)
         ST_IDLE: begin
            if (rise_s) begin
               state_s = ST_PRESS;
               press_s = 1'b1;
               cnt_s   = {CNT_W{1'b0}};
               evt_s   = evt_r + 8'd1;
            end else begin
               cnt_s = {CNT_W{1'b0}};
            end
         end
         ST_PRESS: begin
            if (!bus.boton) begin
               state_s   = ST_IDLE;
               release_s = 1'b1;
               cnt_s     = {CNT_W{1'b0}};
            end else if (cnt_r == LONG_LAST) begin
               state_s = ST_LONG;
               long_s  = 1'b1;
               cnt_s   = {CNT_W{1'b0}};
            end else begin
               cnt_s = cnt_r + CNT_W'(1);
            end
         end
         ST_LONG: begin
            if (!bus.boton) begin
               state_s   = ST_IDLE;
               release_s = 1'b1;
               cnt_s     = {CNT_W{1'b0}};
`ifdef BUTTON_REPEAT_EN
            end else if (cnt_r == REP_LAST) begin
               repeat_s = 1'b1;
               cnt_s    = {CNT_W{1'b0}};
            end else begin
               cnt_s = cnt_r + CNT_W'(1);
            end
`else
            end else begin
               cnt_s = {CNT_W{1'b0}};
            end
`endif
         end
         default: begin
            state_s = ST_IDLE;
            cnt_s   = {CNT_W{1'b0}};
         end
      endcase
      held_s = (state_s != ST_IDLE);
   end

   // State, counter and registered outputs; prev resets high so a button held through reset needs a release first
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= ST_IDLE;
         cnt_r     <= {CNT_W{1'b0}};
         prev_r    <= 1'b1;
         press_r   <= 1'b0;
         release_r <= 1'b0;
         long_r    <= 1'b0;
         held_r    <= 1'b0;
         evt_r     <= 8'd0;
      end else begin
         state_r   <= state_s;
         cnt_r     <= cnt_s;
         prev_r    <= bus.boton;
         press_r   <= press_s;
         release_r <= release_s;
         long_r    <= long_s;
         held_r    <= held_s;
         evt_r     <= evt_s;
      end
   end

`ifdef BUTTON_REPEAT_EN
   // Auto-repeat pulse register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         repeat_r <= 1'b0;
      end else begin
         repeat_r <= repeat_s;
      end
   end
   assign bus.repeat_p = repeat_r;
`else
   assign bus.repeat_p = 1'b0;
`endif

   assign bus.press_p   = press_r;
   assign bus.release_p = release_r;
   assign bus.long_p    = long_r;
   assign bus.held      = held_r;
   assign bus.evt_cnt   = evt_r;

endmodule

// File: tb/tb_button_event_gen.sv
// Bench for button_event_gen (LONG_TICKS=10, REPEAT_TICKS=4). A time-since-press model is compared every cycle.
// Directed scenarios also pin pulse spacing and counts with literal expectations.
module tb_button_event_gen;

   localparam int LONG = 10;
   localparam int RPT  = 4;
`ifdef BUTTON_REPEAT_EN
   localparam bit REP = 1'b1;
`else
   localparam bit REP = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   logic boton;

   button_event_if bif ();
   assign bif.boton = boton;

   button_event_gen #(.CNT_W(8), .LONG_TICKS(LONG), .REPEAT_TICKS(RPT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bif.slave)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // Model state: whether a press is in progress and how many cycles have passed since its press_p
   bit         m_pressed, m_prev;
   int         m_t;
   logic [7:0] m_cnt;
   bit         e_press, e_release, e_long, e_repeat, e_held;

   // Events seen on the DUT, used by the literal checks
   int n_press = 0, n_release = 0, n_long = 0, n_rep = 0, n_held = 0;
   int press_cyc = 0, long_cyc = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_pressed = 1'b0; m_prev = 1'b1; m_t = 0; m_cnt = 8'd0;
      e_press = 1'b0; e_release = 1'b0; e_long = 1'b0; e_repeat = 1'b0; e_held = 1'b0;
   endtask

   task automatic model_step();
      e_press = 1'b0; e_release = 1'b0; e_long = 1'b0; e_repeat = 1'b0;
      if (!rst_n) begin
         model_reset();
      end else begin
         if (!m_pressed) begin
            if (boton && !m_prev) begin
               m_pressed = 1'b1; m_t = 0; e_press = 1'b1; m_cnt = m_cnt + 8'd1;
            end
         end else if (!boton) begin
            m_pressed = 1'b0; e_release = 1'b1;
         end else begin
            m_t++;
            if (m_t == LONG) e_long = 1'b1;
            else if (REP && m_t > LONG && ((m_t - LONG) % RPT) == 0) e_repeat = 1'b1;
         end
         e_held = m_pressed;
         m_prev = boton;
      end
   endtask

   task automatic compare_all();
      check("press_p",   32'(bif.press_p),   32'(e_press));
      check("release_p", 32'(bif.release_p), 32'(e_release));
      check("long_p",    32'(bif.long_p),    32'(e_long));
      check("repeat_p",  32'(bif.repeat_p),  32'(e_repeat));
      check("held",      32'(bif.held),      32'(e_held));
      check("evt_cnt",   32'(bif.evt_cnt),   32'(m_cnt));
   endtask

   task automatic observe();
      if (bif.press_p)   begin n_press++; press_cyc = cyc; end
      if (bif.long_p)    begin n_long++;  long_cyc  = cyc; end
      if (bif.release_p) n_release++;
      if (bif.repeat_p)  n_rep++;
      if (bif.held)      n_held++;
   endtask

   // One clock: model at the edge, compare 1 ns later, return at the falling edge for the next drive
   task automatic tick();
      @(posedge clk);
      cyc++;
      model_step();
      #1;
      compare_all();
      observe();
      @(negedge clk);
   endtask

   task automatic hold(input int n);
      boton = 1'b1;
      repeat (n) tick();
      boton = 1'b0;
      repeat (3) tick();
   endtask

   int p0, r0, l0, q0, h0;

   task automatic snap();
      p0 = n_press; r0 = n_release; l0 = n_long; q0 = n_rep; h0 = n_held;
   endtask

   initial begin
      rst_n = 1'b0;
      boton = 1'b1;
      model_reset();
      @(negedge clk);
      #1;
      check("reset_held", 32'(bif.held), 32'd0);
      check("reset_evt", 32'(bif.evt_cnt), 32'd0);
      repeat (3) tick();

      // Button held through reset release: no press until it goes low first
      rst_n = 1'b1;
      repeat (5) tick();
      check("no_press_after_reset", 32'(n_press), 32'd0);
      boton = 1'b0;
      tick();
      hold(3);
      check("evt_after_first_press", 32'(bif.evt_cnt), 32'd1);
      check("first_press_count", 32'(n_press), 32'd1);

      // Long hold: long_p 10 cycles after press_p, repeats every 4 in repeat builds
      snap();
      hold(31);
      check("long_minus_press", 32'(long_cyc - press_cyc), 32'd10);
      check("long_count", 32'(n_long - l0), 32'd1);
      check("repeat_count_31", 32'(n_rep - q0), REP ? 32'd5 : 32'd0);
      check("release_count_31", 32'(n_release - r0), 32'd1);
      check("evt_after_long", 32'(bif.evt_cnt), 32'd2);

      // Short press: held for exactly 5 cycles, no long_p
      snap();
      hold(5);
      check("short_held_cycles", 32'(n_held - h0), 32'd5);
      check("short_long", 32'(n_long - l0), 32'd0);
      check("short_release", 32'(n_release - r0), 32'd1);

      // Release on the long terminal sample: release only
      snap();
      hold(10);
      check("term_long_none", 32'(n_long - l0), 32'd0);
      check("term_release", 32'(n_release - r0), 32'd1);

      // One more cycle of hold reaches long_p
      snap();
      hold(11);
      check("just_long", 32'(n_long - l0), 32'd1);

      // Release on the repeat terminal sample: no repeat
      snap();
      hold(14);
      check("rterm_long", 32'(n_long - l0), 32'd1);
      check("rterm_repeat_none", 32'(n_rep - q0), 32'd0);
      check("rterm_release", 32'(n_release - r0), 32'd1);

      // 40-cycle hold
      snap();
      hold(40);
      check("hold40_long", 32'(n_long - l0), 32'd1);
      check("hold40_repeat", 32'(n_rep - q0), REP ? 32'd7 : 32'd0);

      // Reset in the LONG state: outputs clear at once, no release_p
      boton = 1'b1;
      repeat (15) tick();
      snap();
      rst_n = 1'b0;
      #1;
      model_reset();
      compare_all();
      check("rst_mid_held", 32'(bif.held), 32'd0);
      @(negedge clk);
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (3) tick();
      boton = 1'b0;
      repeat (3) tick();
      check("rst_no_release", 32'(n_release - r0), 32'd0);
      check("rst_no_press", 32'(n_press - p0), 32'd0);

      // 256 short presses wrap the event counter back to 0
      for (int i = 0; i < 256; i++) hold(2);
      check("wrap_press_count", 32'(n_press - p0), 32'd256);
      check("wrap_evt_cnt", 32'(bif.evt_cnt), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
